// File: rtl/apb_req_master_pkg.sv
// apb_req_master_pkg: state encoding and default widths for the request-to-APB bridge
package apb_req_master_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int REQ_W  = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
endpackage

// File: rtl/apb_req_master.sv
// apb_req_master: converts a 4-phase req/ack handshake into single APB transfers
// Ports: pclk/preset (sync active-high); request side addr_req, req, wr_req, data_send,
// data_reciv, ack, complete; APB side paddr, pwrite, psel, penable, pwdata, prdata, pready.
// Optional APB_TIMEOUT_EN adds TIMEOUT_CYCLES and the timeout_err output.
module apb_req_master #(
  parameter int ADDR_W = apb_req_master_pkg::ADDR_W,
  parameter int DATA_W = apb_req_master_pkg::DATA_W,
`ifdef APB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 256,
`endif
  parameter int REQ_W  = apb_req_master_pkg::REQ_W
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [REQ_W-1:0]  addr_req,
  input  logic              req,
  input  logic              wr_req,
  input  logic [REQ_W-1:0]  data_send,
  output logic [REQ_W-1:0]  data_reciv,
  output logic              ack,
  output logic              complete,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
`ifdef APB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  import apb_req_master_pkg::*;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [REQ_W-1:0] data_reciv_q, data_reciv_d;
  logic pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic ack_q, ack_d, complete_q, complete_d;
  logic unused_hi;
  assign unused_hi = ^{addr_req[REQ_W-1:ADDR_W], data_send[REQ_W-1:DATA_W]};
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`endif
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    psel_d = psel_q;
    penable_d = penable_q;
    data_reciv_d = data_reciv_q;
    complete_d = complete_q;
    ack_d = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        paddr_d = addr_req[ADDR_W-1:0];
        pwdata_d = data_send[DATA_W-1:0];
        pwrite_d = wr_req;
        psel_d = 1'b1;
        penable_d = 1'b0;
        state_d = SETUP;
`ifdef APB_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ACCESS: if (pready) begin
        data_reciv_d = pwrite_q ? data_reciv_q : REQ_W'(prdata);
        psel_d = 1'b0;
        penable_d = 1'b0;
        ack_d = 1'b1;
        complete_d = 1'b1;
        state_d = DONE;
      end
`ifdef APB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        data_reciv_d = pwrite_q ? data_reciv_q : '1;
        psel_d = 1'b0;
        penable_d = 1'b0;
        ack_d = 1'b1;
        complete_d = 1'b1;
        timeout_err_d = 1'b1;
        state_d = DONE;
      end else cnt_d = cnt_q + 1'b1;
`endif
      default: if (!req) begin
        complete_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      paddr_q <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      data_reciv_q <= '0;
      ack_q <= 1'b0;
      complete_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      data_reciv_q <= data_reciv_d;
      ack_q <= ack_d;
      complete_q <= complete_d;
`ifdef APB_TIMEOUT_EN
      cnt_q <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  assign pwrite = pwrite_q;
  assign psel = psel_q;
  assign penable = penable_q;
  assign data_reciv = data_reciv_q;
  assign ack = ack_q;
  assign complete = complete_q;
endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: randomized transfers against a cycle-count model of the bridge
module tb_apb_req_master;
  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic [15:0] addr_req = '0, data_send = '0;
  logic req = 1'b0, wr_req = 1'b0;
  logic [15:0] data_reciv;
  logic ack, complete, pwrite, psel, penable;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata = '0;
  logic pready = 1'b0;
  int errors = 0, checks = 0;
  logic [15:0] exp_rd = '0;
  always #5 pclk = ~pclk;
`ifdef APB_TIMEOUT_EN
  logic timeout_err;
  apb_req_master #(.TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .preset(preset), .addr_req(addr_req), .req(req), .wr_req(wr_req),
    .data_send(data_send), .data_reciv(data_reciv), .ack(ack), .complete(complete),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .timeout_err(timeout_err), .prdata(prdata), .pready(pready));
`else
  apb_req_master dut (
    .pclk(pclk), .preset(preset), .addr_req(addr_req), .req(req), .wr_req(wr_req),
    .data_send(data_send), .data_reciv(data_reciv), .ack(ack), .complete(complete),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready));
`endif
  // One complete request: ack must land exactly 3+waits edges after req is sampled.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rd, input int waits, input int hold, input bit early);
    @(negedge pclk);
    req = 1'b1; wr_req = wr; pready = 1'b1; prdata = 8'($urandom);
    addr_req = {8'($urandom), a}; data_send = {8'($urandom), d};
    @(negedge pclk);
    checks++;
    if ({psel, penable, ack} !== 3'b100) begin
      errors++; $display("FAIL setup_ctl psel/penable/ack=%b want 100", {psel, penable, ack});
    end
    checks++;
    if ({paddr, pwdata, pwrite} !== {a, d, wr}) begin
      errors++; $display("FAIL latch got %h/%h/%b want %h/%h/%b", paddr, pwdata, pwrite, a, d, wr);
    end
`ifdef APB_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear got %b want 0", timeout_err);
    end
`endif
    addr_req = 16'($urandom); data_send = 16'($urandom); wr_req = ~wr;
    if (early) req = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel, penable, ack} !== 3'b110) begin
      errors++; $display("FAIL access_ctl psel/penable/ack=%b want 110", {psel, penable, ack});
    end
    for (int i = 0; i < waits; i++) begin
      pready = 1'b0; prdata = 8'($urandom);
      @(negedge pclk);
      checks++;
      if ({psel, penable, ack, paddr, pwdata, pwrite} !== {3'b110, a, d, wr}) begin
        errors++; $display("FAIL wait%0d ctl=%b addr=%h wdata=%h wr=%b want 110 %h %h %b",
                           i, {psel, penable, ack}, paddr, pwdata, pwrite, a, d, wr);
      end
    end
    pready = 1'b1; prdata = rd;
    @(negedge pclk);
    if (!wr) exp_rd = {8'h00, rd};
    checks++;
    if ({ack, psel, penable, complete} !== 4'b1001) begin
      errors++; $display("FAIL ack_edge ack/psel/penable/complete=%b want 1001", {ack, psel, penable, complete});
    end
    checks++;
    if (data_reciv !== exp_rd) begin
      errors++; $display("FAIL data_reciv got %h want %h", data_reciv, exp_rd);
    end
    for (int i = 0; i < hold; i++) begin
      pready = 1'($urandom); prdata = 8'($urandom);
      @(negedge pclk);
      checks++;
      if ({ack, psel, penable, complete} !== 4'b0001) begin
        errors++; $display("FAIL hold%0d ack/psel/penable/complete=%b want 0001", i, {ack, psel, penable, complete});
      end
    end
    req = 1'b0;
    @(negedge pclk);
    checks++;
    if ({ack, psel, complete} !== 3'b000) begin
      errors++; $display("FAIL release ack/psel/complete=%b want 000", {ack, psel, complete});
    end
  endtask
  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    exp_rd = '0;
    checks++;
    if ({psel, penable, pwrite, ack, complete, paddr, pwdata, data_reciv} !== 37'd0) begin
      errors++; $display("FAIL reset_vals got %b/%h/%h/%h want all 0",
                         {psel, penable, pwrite, ack, complete}, paddr, pwdata, data_reciv);
    end
  endtask
  task automatic test_mid_reset();
    @(negedge pclk);
    req = 1'b1; wr_req = 1'b0; addr_req = 16'h0055; pready = 1'b0;
    repeat (3) @(negedge pclk);
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL pre_reset psel/penable=%b want 11", {psel, penable});
    end
    preset = 1'b1; req = 1'b0;
    @(negedge pclk);
    checks++;
    if ({psel, penable, ack, complete, paddr} !== 12'd0) begin
      errors++; $display("FAIL mid_reset ctl=%b paddr=%h want 0", {psel, penable, ack, complete}, paddr);
    end
    preset = 1'b0;
    exp_rd = '0;
  endtask
  task automatic test_write();
    xfer(1'b1, 8'h03, 8'h01, 8'h00, 0, 2, 1'b0);
  endtask
  task automatic test_read();
    xfer(1'b0, 8'h0A, 8'h00, 8'hA5, 0, 1, 1'b0);
  endtask
  task automatic test_wait_states();
    xfer(1'b0, 8'h21, 8'h00, 8'h3C, 4, 0, 1'b0);
    xfer(1'b1, 8'h22, 8'h99, 8'hEE, 4, 0, 1'b0);
  endtask
  task automatic test_hold();
    xfer(1'b1, 8'h40, 8'h7E, 8'h00, 1, 20, 1'b0);
  endtask
  task automatic test_early_drop();
    xfer(1'b0, 8'h81, 8'h00, 8'h5A, 2, 0, 1'b1);
  endtask
  task automatic test_random();
    for (int n = 0; n < 40; n++)
      xfer(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           $urandom_range(0, 5), $urandom_range(0, 3), 1'b0);
  endtask
`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge pclk);
    req = 1'b1; wr_req = 1'b0; addr_req = 16'h0077; pready = 1'b0;
    repeat (2) @(negedge pclk);
    for (int i = 0; i < 7; i++) begin
      @(negedge pclk);
      checks++;
      if ({ack, psel, timeout_err} !== 3'b010) begin
        errors++; $display("FAIL to_wait%0d ack/psel/err=%b want 010", i, {ack, psel, timeout_err});
      end
    end
    @(negedge pclk);
    exp_rd = 16'hFFFF;
    checks++;
    if ({ack, psel, penable, complete, timeout_err, data_reciv} !== {5'b10011, exp_rd}) begin
      errors++; $display("FAIL timeout ctl=%b data=%h want 10011 %h",
                         {ack, psel, penable, complete, timeout_err}, data_reciv, exp_rd);
    end
    req = 1'b0;
    @(negedge pclk);
    checks++;
    if ({complete, timeout_err} !== 2'b01) begin
      errors++; $display("FAIL to_release complete/err=%b want 01", {complete, timeout_err});
    end
  endtask
`endif
  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_hold();
    test_early_drop();
`ifdef APB_TIMEOUT_EN
    test_timeout();
    test_read();
`endif
    test_random();
    test_mid_reset();
    test_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
